hard_mem_1rw_client: RTL

Request-side master for the byte-masked 1rw hard SRAM wrappers (e.g. the d1024_w32 macro bank). It accepts read/write requests on a valid/ready interface, drives the SRAM port from registers with the macro's active-low chip-select and write-enable, and returns read data on a valid/yumi interface. A credit-managed response FIFO guarantees that no read data is ever lost when the consumer stalls.

---
 rtl/hard_mem_1rw_client.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hard_mem_1rw_client.sv
`default_nettype none
// ============================================================================
// Module   : hard_mem_1rw_client
// Brief    : Request-side master for a byte-masked 1rw hard SRAM. Accepts
//            read/write requests (valid/ready), drives the SRAM from
//            registers, and returns read data through a credit-managed
//            response FIFO (valid/yumi) so no read data is ever dropped.
// Revision : 1.0 - initial release
// ============================================================================
module hard_mem_1rw_client #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_ELS   = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  v_i,
    output logic                  ready_o,
    input  logic                  w_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [MASK_WIDTH-1:0] mask_i,

    output logic                  v_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  yumi_i,

    output logic                  mem_csb_o,
    output logic                  mem_web_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [MASK_WIDTH-1:0] mem_wmask_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    localparam int c_cnt_w = $clog2(FIFO_ELS + 1);
    localparam int c_ptr_w = $clog2(FIFO_ELS);
    localparam logic [c_cnt_w-1:0] c_credit_max = c_cnt_w'(FIFO_ELS);
    localparam logic [c_ptr_w-1:0] c_ptr_last   = c_ptr_w'(FIFO_ELS - 1);

    // Credit / FIFO bookkeeping
    logic [c_cnt_w-1:0]    r_credit;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic                  r_rd_pend;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_ELS];

    // Issue-stage registers driving the SRAM port
    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [MASK_WIDTH-1:0] r_wmask;

    logic w_accept;
    logic w_rd_accept;
    logic w_deq;
    logic w_enq;

    // Pointer advance that wraps at FIFO_ELS, so non power-of-two depths work
    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on the credit register, never on v_i/w_i
    assign ready_o     = (r_credit != '0);
    assign w_accept    = v_i & ready_o;
    assign w_rd_accept = w_accept & ~w_i;
    // A stray yumi with nothing buffered must not corrupt pointers or credits
    assign w_deq       = yumi_i & v_o;
    assign w_enq       = r_rd_pend;

    assign v_o         = (r_count != '0);
    assign data_o      = r_fifo[r_head];

    assign mem_csb_o   = r_csb;
    assign mem_web_o   = r_web;
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign mem_wmask_o = r_wmask;

    // Issue stage: load SRAM strobes and payload on accept, idle otherwise
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_csb   <= 1'b0;
            r_web   <= ~w_i;
            r_addr  <= addr_i;
            r_data  <= data_i;
            r_wmask <= w_i ? mask_i : '0;
        end else begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
        end
    end

    // A read leaving the issue stage is sampled by the SRAM; its data lands next cycle
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= ~r_csb & r_web;
        end
    end

    // Credits: reads take one, consumed responses return one
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_credit <= c_credit_max;
        end else begin
            case ({w_rd_accept, w_deq})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= f_ptr_inc(r_tail);
            end
            if (w_deq) begin
                r_head <= f_ptr_inc(r_head);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response FIFO storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_fifo[r_tail] <= mem_data_i;
        end
    end

`ifndef SYNTHESIS
    // Flag protocol misuse and bookkeeping that breaks the credit invariant
    always @(posedge clk_i) begin
        if (reset_i) begin
            a_no_overflow: assert (!(w_enq && (r_count == c_credit_max)));
            a_yumi_legal:  assert (!(yumi_i && !v_o));
            a_credit_low:  assert (!(w_rd_accept && !w_deq && (r_credit == '0)));
            a_credit_high: assert (!(w_deq && !w_rd_accept && (r_credit == c_credit_max)));
        end
    end
`endif

endmodule
`default_nettype wire
